mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port arbiter and sequencer that shares the single-port `ram_512x32` between the CPU datapath (MAR/MDR path driven by the control unit) and a DMA/loader port. It accepts one request at a time through a req/ack handshake. It drives the RAM address, write-data and write-enable, captures the synchronous read data, and returns it to the winning requester. The block sits between the datapath memory interface and `ram_512x32`; the control unit stalls on `cpu_ack`.

## Interface
- ADDR_W, 9, RAM word-address width (512 words)
- DATA_W, 32, data word width

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read; stable while `cpu_req`
- cpu_addr  in  ADDR_W  CPU word address (from MAR[8:0])
- cpu_wdata  in  DATA_W  CPU write data (from MDR)
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid from the `cpu_ack` cycle until the next CPU read completes
- dma_req / dma_we / dma_addr / dma_wdata  in  1/1/ADDR_W/DATA_W  DMA request, same rules as the CPU port
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  DATA_W  DMA read data, same rules as `cpu_rdata`
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data, valid one clock after the address edge
- busy  out  1  high in any state other than IDLE
- grant  out  2  one-hot current owner: [0] = CPU, [1] = DMA; 00 when idle

## Operation
- States: IDLE, ACCESS, RESP. Transitions are unconditional except the one out of IDLE.
- IDLE:
  - If any req is high, select a winner (see Configuration).
  - Latch the winner's we/addr/wdata into internal registers, set `grant`, and go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (one cycle):
  - `ram_addr` and `ram_wdata` come from the latched registers.
  - `ram_we` = latched we.
  - Go to RESP.
- RESP (one cycle):
  - For a read, load `ram_rdata` into the winner's rdata register.
  - Pulse the winner's ack.
  - Clear `grant` and go to IDLE.
- `ram_we` is high only in ACCESS; it is 0 in every other state.
- `ram_addr` and `ram_wdata` hold their last values outside ACCESS.
- A write leaves the winner's rdata unchanged. The loser's rdata and ack are never touched.
- Requester rule: deassert req, or present the next request, on the edge at which ack is seen. A req still high in IDLE is a new request.
- Requests are latched only in IDLE. Changes to the inputs during ACCESS or RESP are ignored.
- Address arithmetic: no translation. Bits above ADDR_W are dropped by the caller; the block performs no wrap-around.
- Reset (asserted low, at any time, including mid-transfer):
  - State returns to IDLE immediately.
  - `ram_we` = 0, `cpu_ack` = `dma_ack` = 0, `grant` = 00, `busy` = 0.
  - `ram_addr`, `ram_wdata`, `cpu_rdata`, `dma_rdata` = 0.
  - Round-robin pointer points at the CPU (the DMA wins the first tie).
  - A write whose ACCESS edge has not occurred is not performed.

## Timing
- Request first sampled high at edge N (in IDLE).
- ACCESS occupies cycle N+1; the RAM write or read-address capture happens at edge N+2.
- RESP occupies cycle N+2: ack is high and rdata is valid for a read.
- IDLE resumes at cycle N+3. Fastest repeat is one access per 3 cycles per port.
- Fixed latency: 2 cycles from req sampled to ack. With contention, the loser waits one more full 3-cycle transaction.
- `busy` and `grant` are registered and asserted from cycle N+1 through N+2.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on simultaneous requests.
  - A one-bit pointer records the last winner.
  - On a tie, the port that did not win last is granted.
  - The pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority.
  - The CPU always wins a tie.
  - The pointer is not instantiated.
  - The DMA can starve while the CPU requests continuously; this is accepted.

## Test plan
- Reset low for 2 cycles, then high, no requests:
  - All outputs are 0; `busy` stays 0 for 10 cycles.
- CPU write then read:
  - `cpu_we`=1, `addr`=0x005, `wdata`=0xDEADBEEF; `cpu_ack` pulses 2 cycles after the request and `ram_we` is high only in ACCESS.
  - Then `cpu_we`=0, `addr`=0x005; `cpu_ack` pulses with `cpu_rdata`=0xDEADBEEF.
- Simultaneous reads, both reqs held: CPU at addr 0x010 (0x11111111), DMA at addr 0x1FF (0x22222222):
  - With RR after reset: DMA acks first, then CPU acks 3 cycles later; rdata values match.
  - Without RR: CPU acks first.
- Both ports request continuously for 12 transactions:
  - With RR: grants alternate CPU/DMA exactly.
  - Without RR: the DMA receives no ack.
- Reset asserted during ACCESS of a DMA write of 0xCAFEF00D to 0x020, where 0x020 was preloaded with 0x0:
  - No `dma_ack`; state returns to IDLE.
  - A subsequent CPU read of 0x020 returns 0x00000000.
- Requester holds req high through ack:
  - A second identical transaction starts in the IDLE cycle after RESP; exactly two acks in 6 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port ram_512x32 between the CPU datapath port and a
// DMA/loader port. Each accepted request takes IDLE -> ACCESS -> RESP.
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking; when it is undefined, the CPU
// wins every tie (fixed priority).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  // Status
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              pick_dma;

`ifdef MEM_ARB_RR_EN
  // Last winner: 0 = CPU, 1 = DMA. Reset to CPU so the DMA wins the first tie.
  logic last_dma_q, last_dma_d;

  // Winner select: on a tie, grant the port that did not win last.
  always_comb pick_dma = dma_req & (~cpu_req | ~last_dma_q);
`else
  // Winner select: the CPU always wins a tie.
  always_comb pick_dma = dma_req & ~cpu_req;
`endif

  // Next-state and registered-output computation for the three-state sequencer.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_dma_d  = last_dma_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cpu_req | dma_req) begin
          // The latched address/data registers drive the RAM directly, so they also
          // hold their value once the access is over.
          state_d     = StAccess;
          busy_d      = 1'b1;
          grant_d     = pick_dma ? 2'b10 : 2'b01;
          we_d        = pick_dma ? dma_we : cpu_we;
          ram_we_d    = pick_dma ? dma_we : cpu_we;
          ram_addr_d  = pick_dma ? dma_addr : cpu_addr;
          ram_wdata_d = pick_dma ? dma_wdata : cpu_wdata;
`ifdef MEM_ARB_RR_EN
          last_dma_d  = pick_dma;
`endif
        end
      end
      StAccess: begin
        state_d   = StResp;
        cpu_ack_d = grant_q[0];
        dma_ack_d = grant_q[1];
      end
      StResp: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        grant_d = 2'b00;
        if (!we_q && grant_q[0]) cpu_rdata_d = ram_rdata;
        if (!we_q && grant_q[1]) dma_rdata_d = ram_rdata;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_dma_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_dma_q  <= last_dma_d;
`endif
    end
  end

  // RAM read data only arrives in RESP, so forward it during the ack cycle; the rdata
  // registers hold it afterwards.
  always_comb begin
    cpu_rdata = cpu_rdata_q;
    dma_rdata = dma_rdata_q;
    if (state_q == StResp && !we_q && grant_q[0]) cpu_rdata = ram_rdata;
    if (state_q == StResp && !we_q && grant_q[1]) dma_rdata = ram_rdata;
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table-driven single-port transactions, directed contention
// and reset sequences, and randomized traffic against a transaction-level reference model.
// Expectations follow MEM_ARB_RR_EN the same way the design does.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
  logic          cpu_ack, dma_ack, ram_we, busy;
  logic [1:0]    grant;
  logic          mem_clr;
  logic [DW-1:0] mem [512];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM stand-in (ram_512x32 behaviour).
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
      ram_rdata <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit dma, input bit req, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    if (dma) begin
      dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic do_reset(input bit clr);
    reset = 1'b0;
    mem_clr = clr;
    tick();
    tick();
    reset = 1'b1;
    mem_clr = 1'b0;
  endtask

  // One isolated transaction, entered right after an edge with the block idle.
  task automatic run_txn(input bit dma, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                         input logic [DW-1:0] exp_other, input string tag);
    logic [1:0] g;
    g = dma ? 2'b10 : 2'b01;
    set_port(dma, 1'b1, we, addr, wdata);
    tick();  // ACCESS
    chk({tag, " access grant"}, grant, g);
    chk({tag, " access busy"}, busy, 1);
    chk({tag, " access ram_we"}, ram_we, we);
    chk({tag, " access ram_addr"}, ram_addr, addr);
    if (we) chk({tag, " access ram_wdata"}, ram_wdata, wdata);
    chk({tag, " access acks"}, {cpu_ack, dma_ack}, 0);
    tick();  // RESP
    chk({tag, " resp ack"}, dma ? {dma_ack, cpu_ack} : {cpu_ack, dma_ack}, 2'b10);
    chk({tag, " resp ram_we"}, ram_we, 0);
    chk({tag, " resp rdata"}, dma ? dma_rdata : cpu_rdata, exp_rd);
    chk({tag, " resp other rdata"}, dma ? cpu_rdata : dma_rdata, exp_other);
    set_port(dma, 1'b0, 1'b0, '0, '0);
    tick();  // IDLE
    chk({tag, " idle busy/grant"}, {busy, grant}, 0);
    chk({tag, " idle acks"}, {cpu_ack, dma_ack}, 0);
    chk({tag, " idle rdata held"}, dma ? dma_rdata : cpu_rdata, exp_rd);
    chk({tag, " idle ram_addr held"}, ram_addr, addr);
  endtask

  typedef struct {
    bit            dma;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;  // requester's rdata after the transaction
  } vec_t;

  vec_t vecs [8];

  // Reference model state for the random phase.
  logic [DW-1:0] mem_ref [512];
  int            t_start, n_acks, n_dma, cpu_cyc, dma_cyc, phase;
  bit            t_dma, t_we, last_dma;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, exp_cr, exp_dr, cap_c, cap_d, exp_oth;
  bit            e_cack, e_dack, e_busy;
  logic [1:0]    e_grant;
  int            seq [$];

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 9'h1FF;
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    vecs[0] = '{0, 1, 9'h005, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 0, 9'h005, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1, 1, 9'h1FF, 32'h22222222, 32'h0};
    vecs[3] = '{0, 1, 9'h010, 32'h11111111, 32'hDEADBEEF};
    vecs[4] = '{1, 0, 9'h010, 32'h0, 32'h11111111};
    vecs[5] = '{0, 0, 9'h1FF, 32'h0, 32'h22222222};
    vecs[6] = '{1, 1, 9'h000, 32'h12345678, 32'h11111111};
    vecs[7] = '{1, 0, 9'h000, 32'h0, 32'h12345678};

    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state and quiet idle.
    reset = 1'b0;
    mem_clr = 1'b1;
    tick();
    tick();
    chk("reset ram side", {ram_we, ram_addr, 1'b0}, 0);
    chk("reset ram_wdata", ram_wdata, 0);
    chk("reset acks/busy/grant", {cpu_ack, dma_ack, busy, grant}, 0);
    chk("reset cpu_rdata", cpu_rdata, 0);
    chk("reset dma_rdata", dma_rdata, 0);
    reset = 1'b1;
    mem_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle busy", {busy, grant, ram_we, cpu_ack, dma_ack}, 0);
    end

    // Table of isolated transactions.
    exp_cr = '0;
    exp_dr = '0;
    for (int i = 0; i < 8; i++) begin
      exp_oth = vecs[i].dma ? exp_cr : exp_dr;
      run_txn(vecs[i].dma, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
              exp_oth, $sformatf("vec%0d", i));
      if (vecs[i].dma) exp_dr = vecs[i].exp_rdata;
      else exp_cr = vecs[i].exp_rdata;
    end

    // Simultaneous reads, each requester drops req once acked.
    do_reset(1'b0);
    set_port(1'b0, 1'b1, 1'b0, 9'h010, '0);
    set_port(1'b1, 1'b1, 1'b0, 9'h1FF, '0);
    cpu_cyc = -1;
    dma_cyc = -1;
    cap_c = '0;
    cap_d = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (cpu_ack) begin cpu_cyc = c; cap_c = cpu_rdata; cpu_req = 1'b0; end
      if (dma_ack) begin dma_cyc = c; cap_d = dma_rdata; dma_req = 1'b0; end
    end
    chk("tie cpu ack cycle", cpu_cyc, RR ? 5 : 2);
    chk("tie dma ack cycle", dma_cyc, RR ? 2 : 5);
    chk("tie cpu rdata", cap_c, 32'h11111111);
    chk("tie dma rdata", cap_d, 32'h22222222);

    // Both ports requesting continuously for 12 transaction slots.
    do_reset(1'b0);
    set_port(1'b0, 1'b1, 1'b0, 9'h005, '0);
    set_port(1'b1, 1'b1, 1'b0, 9'h000, '0);
    seq.delete();
    n_dma = 0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (cpu_ack && dma_ack) chk("continuous dual ack", 1, 0);
      if (cpu_ack) seq.push_back(0);
      if (dma_ack) begin seq.push_back(1); n_dma++; end
    end
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    chk("continuous ack count", seq.size(), 12);
    chk("continuous dma acks", n_dma, RR ? 6 : 0);
    foreach (seq[i]) chk($sformatf("continuous winner %0d", i), seq[i], RR ? ((i % 2) == 0) : 0);
    tick();
    tick();

    // Reset during ACCESS of a DMA write must suppress the write.
    do_reset(1'b0);
    run_txn(1'b0, 1'b1, 9'h020, 32'h0, 32'h0, 32'h0, "preload");
    set_port(1'b1, 1'b1, 1'b1, 9'h020, 32'hCAFEF00D);
    tick();
    chk("abort access ram_we", ram_we, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort async ram_we", ram_we, 0);
    chk("abort async busy/grant", {busy, grant}, 0);
    tick();
    chk("abort no dma_ack", dma_ack, 0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    chk("abort after release", {dma_ack, busy, grant}, 0);
    run_txn(1'b0, 1'b0, 9'h020, '0, 32'h0, 32'h0, "abort readback");

    // Request held through ack starts a back-to-back transaction.
    set_port(1'b0, 1'b1, 1'b0, 9'h005, '0);
    n_acks = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (cpu_ack) begin
        n_acks++;
        chk("held rdata", cpu_rdata, 32'hDEADBEEF);
      end
    end
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    chk("held ack count", n_acks, 2);
    tick();
    tick();

    // Randomized traffic against the transaction-level model.
    do_reset(1'b1);
    for (int i = 0; i < 512; i++) mem_ref[i] = '0;
    t_start = -100;
    t_dma = 1'b0;
    t_we = 1'b0;
    t_addr = '0;
    t_wdata = '0;
    last_dma = 1'b0;
    exp_cr = '0;
    exp_dr = '0;
    n_acks = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(posedge clk);
      // A new transaction may start 3 edges after the previous one was accepted.
      if (cyc >= t_start + 3 && (cpu_req || dma_req)) begin
        if (cpu_req && dma_req) t_dma = RR ? !last_dma : 1'b0;
        else t_dma = dma_req;
        last_dma = t_dma;
        t_start = cyc;
        t_we = t_dma ? dma_we : cpu_we;
        t_addr = t_dma ? dma_addr : cpu_addr;
        t_wdata = t_dma ? dma_wdata : cpu_wdata;
      end
      phase = cyc - t_start;
      e_busy = (phase == 0) || (phase == 1);
      e_grant = e_busy ? (t_dma ? 2'b10 : 2'b01) : 2'b00;
      e_cack = (phase == 1) && !t_dma;
      e_dack = (phase == 1) && t_dma;
      if (phase == 1) begin
        n_acks++;
        if (t_we) mem_ref[t_addr] = t_wdata;
        else if (t_dma) exp_dr = mem_ref[t_addr];
        else exp_cr = mem_ref[t_addr];
      end
      #1;
      chk("rand busy", busy, e_busy);
      chk("rand grant", grant, e_grant);
      chk("rand acks", {cpu_ack, dma_ack}, {e_cack, e_dack});
      chk("rand ram_we", ram_we, (phase == 0) && t_we);
      chk("rand ram_addr", ram_addr, t_addr);
      chk("rand ram_wdata", ram_wdata, t_wdata);
      chk("rand cpu_rdata", cpu_rdata, exp_cr);
      chk("rand dma_rdata", dma_rdata, exp_dr);
      // Requesters: hold until acked, then issue another request or go quiet.
      if (cpu_req ? (e_cack && $urandom_range(0, 1) == 1) : ($urandom_range(0, 9) < 4))
        set_port(1'b0, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      else if (e_cack) set_port(1'b0, 1'b0, 1'b0, '0, '0);
      if (dma_req ? (e_dack && $urandom_range(0, 1) == 1) : ($urandom_range(0, 9) < 4))
        set_port(1'b1, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      else if (e_dack) set_port(1'b1, 1'b0, 1'b0, '0, '0);
    end
    chk("rand activity", n_acks > 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
